// File: rtl/fp_issue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fp_issue_pkg                                                   |
// | Shared opcode map, FSM encoding and widths for the FP issue sequencer.   |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
package fp_issue_pkg;

    localparam int OP_VEC_W = 17;

    localparam logic [4:0] FP_OP_FMADD    = 5'd0;
    localparam logic [4:0] FP_OP_FMSUB    = 5'd1;
    localparam logic [4:0] FP_OP_FNMADD   = 5'd2;
    localparam logic [4:0] FP_OP_FNMSUB   = 5'd3;
    localparam logic [4:0] FP_OP_FADD     = 5'd4;
    localparam logic [4:0] FP_OP_FSUB     = 5'd5;
    localparam logic [4:0] FP_OP_FMUL     = 5'd6;
    localparam logic [4:0] FP_OP_FSGNJ    = 5'd7;
    localparam logic [4:0] FP_OP_FCMP     = 5'd8;
    localparam logic [4:0] FP_OP_FMAX     = 5'd9;
    localparam logic [4:0] FP_OP_FCLASS   = 5'd10;
    localparam logic [4:0] FP_OP_FMV_I2F  = 5'd11;
    localparam logic [4:0] FP_OP_FMV_F2I  = 5'd12;
    localparam logic [4:0] FP_OP_FCVT_I2F = 5'd13;
    localparam logic [4:0] FP_OP_FCVT_F2I = 5'd14;
    localparam logic [4:0] FP_OP_LAST     = FP_OP_FCVT_F2I;

    localparam logic [2:0] RM_DYN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_op_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fp_op_decode                                                   |
// | Expands the compact FP opcode into the FP unit's one-hot op vector.      |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_op_decode
    import fp_issue_pkg::*;
(
    input  logic [4:0]          op_i,
    input  logic [1:0]          sub_i,
    output logic [OP_VEC_W-1:0] vec_o,
    output logic                illegal_o
);

    logic [4:0] w_idx;

    // Opcode n maps to bit 16-n; the low two bits carry the fcvt sub-field.
    assign w_idx = 5'd16 - op_i;

    always_comb begin
        vec_o     = '0;
        illegal_o = 1'b0;
        if (op_i > FP_OP_LAST) begin
            illegal_o = 1'b1;
        end else begin
            vec_o[w_idx] = 1'b1;
            vec_o[1:0]   = sub_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fp_issue_ctrl                                                  |
// | Issue/wait/writeback sequencer for the FP unit with sticky fflags.       |
// | Rev     : 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_issue_ctrl
    import fp_issue_pkg::*;
#(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_op,
    input  logic [1:0]          req_sub,
    input  logic [1:0]          req_fmt,
    input  logic [2:0]          req_rm,
    input  logic [RD_W-1:0]     req_rd,
    input  logic [31:0]         req_data1,
    input  logic [31:0]         req_data2,
    input  logic [31:0]         req_data3,
    input  logic [2:0]          frm,
    output logic [31:0]         fu_data1,
    output logic [31:0]         fu_data2,
    output logic [31:0]         fu_data3,
    output logic [OP_VEC_W-1:0] fu_op,
    output logic [1:0]          fu_fmt,
    output logic [2:0]          fu_rm,
    output logic                fu_enable,
    input  logic [31:0]         fu_result,
    input  logic [4:0]          fu_flags,
    input  logic                fu_ready,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [RD_W-1:0]     wb_rd,
    output logic [31:0]         wb_result,
    output logic [4:0]          wb_flags,
    output logic                wb_illegal,
    output logic                wb_timeout,
    output logic [4:0]          fflags,
    input  logic                fflags_clr,
    output logic                busy
);

    localparam int              CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           data1_q, data1_d, data2_q, data2_d, data3_q, data3_d;
    logic [OP_VEC_W-1:0]   op_q, op_d;
    logic [1:0]            fmt_q, fmt_d;
    logic [2:0]            rm_q, rm_d;
    logic [RD_W-1:0]       rd_q, rd_d;
    logic [31:0]           result_q, result_d;
    logic [4:0]            flags_q, flags_d, fflags_q, fflags_d;
    logic                  illegal_q, illegal_d, timeout_q, timeout_d;

    logic [OP_VEC_W-1:0]   w_dec_vec;
    logic                  w_dec_illegal;
    logic                  w_wb_fire;

    fp_op_decode u_dec (
        .op_i      (req_op),
        .sub_i     (req_sub),
        .vec_o     (w_dec_vec),
        .illegal_o (w_dec_illegal)
    );

    assign w_wb_fire = (state_q == ST_DONE) && wb_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        data3_d   = data3_q;
        op_d      = op_q;
        fmt_d     = fmt_q;
        rm_d      = rm_q;
        rd_d      = rd_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rd_d      = req_rd;
                    timeout_d = 1'b0;
                    if (w_dec_illegal) begin
                        illegal_d = 1'b1;
                        result_d  = '0;
                        flags_d   = '0;
                        state_d   = ST_DONE;
                    end else begin
                        illegal_d = 1'b0;
                        data1_d   = req_data1;
                        data2_d   = req_data2;
                        data3_d   = req_data3;
                        op_d      = w_dec_vec;
                        fmt_d     = req_fmt;
                        rm_d      = (req_rm == RM_DYN) ? frm : req_rm;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (fu_ready) begin
                    result_d = fu_result;
                    flags_d  = fu_flags;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response on the expiry cycle still counts as a normal completion.
                if (fu_ready) begin
                    result_d = fu_result;
                    flags_d  = fu_flags;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    result_d  = '0;
                    flags_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr) begin
            fflags_d = w_wb_fire ? flags_q : 5'd0;
        end else if (w_wb_fire) begin
            fflags_d = fflags_q | flags_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            data3_q   <= '0;
            op_q      <= '0;
            fmt_q     <= '0;
            rm_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            fflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            data3_q   <= data3_d;
            op_q      <= op_d;
            fmt_q     <= fmt_d;
            rm_q      <= rm_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            fflags_q  <= fflags_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign fu_enable  = (state_q == ST_ISSUE);
    assign wb_valid   = (state_q == ST_DONE);
    assign fu_data1   = data1_q;
    assign fu_data2   = data2_q;
    assign fu_data3   = data3_q;
    assign fu_op      = op_q;
    assign fu_fmt     = fmt_q;
    assign fu_rm      = rm_q;
    assign wb_rd      = rd_q;
    assign wb_result  = result_q;
    assign wb_flags   = flags_q;
    assign wb_illegal = illegal_q;
    assign wb_timeout = timeout_q;
    assign fflags     = fflags_q;

endmodule
`default_nettype wire
